// File: rtl/z16_pkg.sv
// Shared definitions for the Z16 data-memory arbiter: widths, master indices,
// the memory request bundle and the one-hot grant encoding.
package z16_pkg;

    localparam int Z16_ADDR_W = 16;
    localparam int Z16_DATA_W = 16;

    localparam bit M0 = 1'b0;
    localparam bit M1 = 1'b1;

    typedef struct packed {
        logic                  we;
        logic [Z16_ADDR_W-1:0] addr;
        logic [Z16_DATA_W-1:0] wdata;
    } z16_mem_req_t;

    // Bit index of each grant value matches the master index.
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_M0   = 2'b01,
        GNT_M1   = 2'b10
    } z16_gnt_e;

endpackage

// File: rtl/z16_rr_arb2.sv
// Two-way round-robin grant with a master-1 lock override that is forcibly
// broken when master 0 has waited out the lock budget.
module z16_rr_arb2
    import z16_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last,
    input  logic       i_locked,
    input  logic       i_lock_at_max,
    output z16_gnt_e   o_grant,
    output logic       o_force_release
);

    always_comb begin
        o_grant         = GNT_NONE;
        o_force_release = 1'b0;
        if (i_locked && i_valid[M1]) begin
            if (i_valid[M0] && i_lock_at_max) begin
                o_grant         = GNT_M0;
                o_force_release = 1'b1;
            end else begin
                o_grant = GNT_M1;
            end
        end else begin
            case (i_valid)
                2'b01:   o_grant = GNT_M0;
                2'b10:   o_grant = GNT_M1;
                // Tie: the master that did not win last time goes first.
                2'b11:   o_grant = i_last ? GNT_M0 : GNT_M1;
                default: o_grant = GNT_NONE;
            endcase
        end
    end

endmodule

// File: rtl/z16_dmem_arbiter.sv
// Shares the Z16 data-memory port between the CPU (master 0) and a DMA/debug
// engine (master 1); reads return registered data one cycle after acceptance.
module z16_dmem_arbiter
    import z16_pkg::*;
#(
    parameter int P_ADDR_W   = Z16_ADDR_W,
    parameter int P_DATA_W   = Z16_DATA_W,
    parameter int P_LOCK_MAX = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_m0_valid,
    input  logic                i_m0_we,
    input  logic [P_ADDR_W-1:0] i_m0_addr,
    input  logic [P_DATA_W-1:0] i_m0_wdata,
    output logic                o_m0_ready,
    output logic                o_m0_rvalid,
    output logic [P_DATA_W-1:0] o_m0_rdata,
    input  logic                i_m1_valid,
    input  logic                i_m1_we,
    input  logic [P_ADDR_W-1:0] i_m1_addr,
    input  logic [P_DATA_W-1:0] i_m1_wdata,
    input  logic                i_m1_lock,
    output logic                o_m1_ready,
    output logic                o_m1_rvalid,
    output logic [P_DATA_W-1:0] o_m1_rdata,
    output logic [P_ADDR_W-1:0] o_mem_addr,
    output logic                o_mem_we,
    output logic [P_DATA_W-1:0] o_mem_wdata,
    input  logic [P_DATA_W-1:0] i_mem_rdata
);

    localparam int               CNT_W      = $clog2(P_LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(P_LOCK_MAX);

    logic             r_last;
    logic             r_locked;
    logic [CNT_W-1:0] r_lock_cnt;

    logic [1:0]       w_valid;
    logic [1:0]       w_we;
    logic [1:0]       w_acc;
    z16_gnt_e         w_grant;
    logic             w_force_release;
    logic             w_locked_next;
    logic [CNT_W-1:0] w_lock_cnt_next;

    // Holding requests off during reset keeps ready and the memory port quiet.
    assign w_valid = i_rst ? 2'b00 : {i_m1_valid, i_m0_valid};
    assign w_we    = {i_m1_we, i_m0_we};

    z16_rr_arb2 u_arb (
        .i_valid         (w_valid),
        .i_last          (r_last),
        .i_locked        (r_locked),
        .i_lock_at_max   (r_lock_cnt == LOCK_MAX_C),
        .o_grant         (w_grant),
        .o_force_release (w_force_release)
    );

    assign w_acc      = w_grant;
    assign o_m0_ready = w_acc[M0];
    assign o_m1_ready = w_acc[M1];

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_acc[M0]) begin
            o_mem_we    = i_m0_we;
            o_mem_addr  = i_m0_addr;
            o_mem_wdata = i_m0_wdata;
        end else if (w_acc[M1]) begin
            o_mem_we    = i_m1_we;
            o_mem_addr  = i_m1_addr;
            o_mem_wdata = i_m1_wdata;
        end
    end

    // The grant that takes the lock already counts as the first beat of the
    // burst, so master 0 waits at most P_LOCK_MAX master-1 grants in total.
    always_comb begin
        w_locked_next = r_locked;
        if (w_force_release) begin
            w_locked_next = 1'b0;
        end else if (w_acc[M1]) begin
            w_locked_next = i_m1_lock;
        end else if (!i_m1_valid) begin
            w_locked_next = 1'b0;
        end

        w_lock_cnt_next = r_lock_cnt;
        if (!w_locked_next) begin
            w_lock_cnt_next = '0;
        end else if (w_acc[M1] && i_m0_valid && (r_lock_cnt != LOCK_MAX_C)) begin
            w_lock_cnt_next = r_lock_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last     <= 1'b1;
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            if (w_acc[M1]) begin
                r_last <= 1'b1;
            end else if (w_acc[M0]) begin
                r_last <= 1'b0;
            end
            r_locked   <= w_locked_next;
            r_lock_cnt <= w_lock_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            logic                r_rvalid;
            logic [P_DATA_W-1:0] r_rdata;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_rvalid <= 1'b0;
                    r_rdata  <= '0;
                end else begin
                    r_rvalid <= w_acc[gi] & ~w_we[gi];
                    if (w_acc[gi] && !w_we[gi]) begin
                        r_rdata <= i_mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign o_m0_rvalid = g_resp[0].r_rvalid;
    assign o_m0_rdata  = g_resp[0].r_rdata;
    assign o_m1_rvalid = g_resp[1].r_rvalid;
    assign o_m1_rdata  = g_resp[1].r_rdata;

endmodule

// File: doc/z16_dmem_arbiter.md
Name: z16_dmem_arbiter

Overview:
Two-requester arbiter that shares the single Z16 data-memory port between the CPU load/store path (master 0) and a DMA/debug engine (master 1). Each master uses a valid/ready request handshake. The arbiter grants one request per cycle using round-robin priority. An optional lock lets master 1 hold the port for bursts, bounded by a watchdog counter. Read data is registered and returned one cycle after acceptance with a per-master rvalid strobe.

Parameters:
P_ADDR_W, 16, address width in bits
P_DATA_W, 16, data width in bits
P_LOCK_MAX, 8, max consecutive master-1 locked grants while master 0 waits (>=1)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous, active-high reset
i_m0_valid  in  1  master 0 request valid
i_m0_we  in  1  master 0 write (1) / read (0)
i_m0_addr  in  P_ADDR_W  master 0 byte address
i_m0_wdata  in  P_DATA_W  master 0 write data
o_m0_ready  out  1  master 0 request accepted this cycle
o_m0_rvalid  out  1  master 0 read data valid
o_m0_rdata  out  P_DATA_W  master 0 read data
i_m1_valid, i_m1_we, i_m1_addr, i_m1_wdata  in  same widths as master 0  master 1 request
i_m1_lock  in  1  master 1 requests the port be held after this grant
o_m1_ready, o_m1_rvalid, o_m1_rdata  out  same widths as master 0  master 1 response
o_mem_addr  out  P_ADDR_W  memory address
o_mem_we  out  1  memory write enable
o_mem_wdata  out  P_DATA_W  memory write data
i_mem_rdata  in  P_DATA_W  memory read data (combinational from o_mem_addr)

Behaviour:
- Reset: r_last=1 (master 0 wins the first tie), r_locked=0, r_lock_cnt=0. o_mX_rvalid=0, o_mX_rdata=0. ready and mem outputs are combinational and equal 0 while i_rst=1.
- Grant is combinational per cycle:
  - Exactly one master valid: that master is granted.
  - Both valid, not locked: grant the master != r_last.
  - r_locked=1 and i_m1_valid=1: grant master 1, unless i_m0_valid=1 and r_lock_cnt==P_LOCK_MAX. In that case grant master 0 and clear the lock.
- Granted master: ready=1. o_mem_addr, o_mem_we and o_mem_wdata are driven from that master.
- No grant: o_mem_we=0, o_mem_addr=0, o_mem_wdata=0.
- A write commits at the accepting clock edge; no rvalid is produced.
- A read is sampled at the accepting edge: i_mem_rdata goes to o_mX_rdata and o_mX_rvalid=1 for exactly one cycle. Latency is 1 cycle.
- rdata holds its last value when rvalid=0.
- Back-to-back accepts are allowed every cycle; throughput is 1 request/cycle.
- r_last updates to the granted index on each accept and is unchanged when idle.
- Lock:
  - r_locked<=1 on a master-1 accept with i_m1_lock=1.
  - r_locked<=0 on a master-1 accept with i_m1_lock=0, on a cycle with i_m1_valid=0, or on a forced release.
- r_lock_cnt:
  - Increments on each locked master-1 grant while i_m0_valid=1, saturating at P_LOCK_MAX.
  - Resets to 0 on any master-0 grant or whenever r_locked=0.
- A master must hold valid and payload stable until ready. The arbiter does not check this.
- Reset mid-operation: a pending rvalid is dropped and the lock is cleared.

Decomposition:
- Package z16_pkg holds: Z16_ADDR_W=16, Z16_DATA_W=16, master index constants M0=0 and M1=1, and a mem-request struct typedef {we, addr, wdata}.
- One natural sub-module: z16_rr_arb2 (2-way round-robin grant from valid bits and r_last, plus the lock override inputs). The response registers stay in the top.

Test Plan:
- M0 only, read addr 0x0010 with the memory model returning 0xBEEF -> o_m0_ready=1 same cycle; next cycle o_m0_rvalid=1, o_m0_rdata=0xBEEF; o_m1_rvalid=0.
- Both valid every cycle for 6 cycles, no lock -> grants alternate M0,M1,M0,M1,M0,M1, each ready for one cycle, never both.
- M1 write 0x1234 to 0x0040 then M0 read 0x0040 -> o_mem_we=1 only in the M1 cycle; the M0 read returns 0x1234 one cycle later; no rvalid for the write.
- M1 locked burst (i_m1_lock=1) with M0 valid throughout, P_LOCK_MAX=8 -> M1 is granted 8 consecutive cycles, M0 on the 9th, then round-robin resumes.
- Lock dropped early (i_m1_lock=0 on the 3rd beat) -> M0 is granted on the next cycle; r_lock_cnt returns to 0.
- Assert i_rst one cycle after an M0 read accept -> o_m0_rvalid stays 0; ready=0 during reset; the first post-reset tie is granted to M0.
